// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply control block.
package mult_hilo_ctrl_pkg;

  localparam int MULT_W      = 32;
  localparam int PROD_W      = 64;
  localparam int MAX_CYC_DEF = 40;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mult_timeout_cnt.sv
// Busy-cycle counter for the multiplier watchdog; tmo_o fires in the
// MAX_CYC-th consecutive BUSY cycle that has no prodv.
module mult_timeout_cnt #(
  parameter int MAX_CYC = 40,
  parameter int CNT_W   = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic busy_i,
  input  logic prodv_i,
  output logic tmo_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on entry to BUSY, advance while BUSY.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (busy_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo_o = busy_i & ~prodv_i & (cnt_q == CNT_W'(MAX_CYC - 1));

endmodule

// File: rtl/mult_hilo_ctrl.sv
// EX-stage control for MultSerial: launches multiplies, owns HI/LO, stalls.
// Optional watchdog built only when MULT_TIMEOUT_EN is defined.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
`ifdef MULT_TIMEOUT_EN
#(
  parameter int MAX_CYC = MAX_CYC_DEF,
  parameter int CNT_W   = 6
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mult,
  input  logic              ex_signed,
  input  logic [MULT_W-1:0] ex_a,
  input  logic [MULT_W-1:0] ex_b,
  input  logic              ex_mfhi,
  input  logic              ex_mflo,
  input  logic              ex_mthi,
  input  logic              ex_mtlo,
  input  logic [MULT_W-1:0] ex_wdata,
  output logic              mst,
  output logic              msgn,
  output logic [MULT_W-1:0] srcA,
  output logic [MULT_W-1:0] srcB,
  input  logic [PROD_W-1:0] prod,
  input  logic              prodv,
  output logic [MULT_W-1:0] rd_data,
  output logic              stall,
  output logic [MULT_W-1:0] hi,
  output logic [MULT_W-1:0] lo,
  output logic              err
);

  state_e            state_q, state_d;
  logic [MULT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [MULT_W-1:0] srca_q, srca_d, srcb_q, srcb_d;
  logic              msgn_q, msgn_d;
  logic              enter_busy_s;
  logic              tmo_s;
  logic              any_wr_s, any_rd_s, any_req_s;

  assign any_wr_s  = ex_mthi | ex_mtlo;
  assign any_rd_s  = ex_mfhi | ex_mflo;
  assign any_req_s = ex_mult | any_wr_s | any_rd_s;

  // Next-state, HI/LO update and EX-facing outputs.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    msgn_d       = msgn_q;
    srca_d       = srca_q;
    srcb_d       = srcb_q;
    enter_busy_s = 1'b0;
    mst          = 1'b0;
    msgn         = msgn_q;
    srcA         = srca_q;
    srcB         = srcb_q;
    stall        = 1'b0;
    rd_data      = {MULT_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (ex_mult) begin
          // Operands go straight to MultSerial in the launch cycle.
          mst          = 1'b1;
          msgn         = ex_signed;
          srcA         = ex_a;
          srcB         = ex_b;
          msgn_d       = ex_signed;
          srca_d       = ex_a;
          srcb_d       = ex_b;
          enter_busy_s = 1'b1;
          state_d      = ST_BUSY;
        end else if (any_wr_s) begin
          if (ex_mthi) hi_d = ex_wdata; else hi_d = hi_q;
          if (ex_mtlo) lo_d = ex_wdata; else lo_d = lo_q;
        end else if (ex_mfhi) begin
          rd_data = hi_q;
        end else if (ex_mflo) begin
          rd_data = lo_q;
        end else begin
          rd_data = {MULT_W{1'b0}};
        end
      end
      ST_BUSY: begin
        if (prodv) begin
          hi_d    = prod[PROD_W-1:MULT_W];
          lo_d    = prod[MULT_W-1:0];
          state_d = ST_IDLE;
          // Writes/new multiplies wait one cycle so they land after the product.
          if (ex_mult | any_wr_s) begin
            stall = 1'b1;
          end else if (ex_mfhi) begin
            rd_data = prod[PROD_W-1:MULT_W];
          end else if (ex_mflo) begin
            rd_data = prod[MULT_W-1:0];
          end else begin
            stall = 1'b0;
          end
        end else if (tmo_s) begin
          stall   = any_req_s;
          state_d = ST_IDLE;
        end else begin
          stall = any_req_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Architectural and launch-operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= {MULT_W{1'b0}};
      lo_q    <= {MULT_W{1'b0}};
      msgn_q  <= 1'b0;
      srca_q  <= {MULT_W{1'b0}};
      srcb_q  <= {MULT_W{1'b0}};
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      msgn_q  <= msgn_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

`ifdef MULT_TIMEOUT_EN
  logic err_q;

  mult_timeout_cnt #(
    .MAX_CYC (MAX_CYC),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (enter_busy_s),
    .busy_i  (state_q == ST_BUSY),
    .prodv_i (prodv),
    .tmo_o   (tmo_s)
  );

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | tmo_s;
    end
  end

  assign err = err_q;
`else
  assign tmo_s = 1'b0;
  assign err   = 1'b0;
`endif

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Execute-stage control block that sits in front of MultSerial and consumes its result.
- Accepts MULT/MULTU, MFHI/MFLO and MTHI/MTLO requests from the EX stage.
- Launches the serial multiplier and captures prod on prodv into architectural HI/LO.
- Generates the pipeline stall while a multiply is outstanding.

Parameters:
- MAX_CYC, 40, cycles in BUSY without prodv before timeout (only with MULT_TIMEOUT_EN).
- CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > MAX_CYC.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mult  in  1  MULT/MULTU request this cycle.
- ex_signed  in  1  1 = MULT (signed), 0 = MULTU.
- ex_a  in  32  multiplicand.
- ex_b  in  32  multiplier.
- ex_mfhi  in  1  read HI request.
- ex_mflo  in  1  read LO request.
- ex_mthi  in  1  write HI request.
- ex_mtlo  in  1  write LO request.
- ex_wdata  in  32  data for MTHI/MTLO.
- mst  out  1  start pulse to MultSerial.
- msgn  out  1  signed-mode select to MultSerial.
- srcA  out  32  operand A to MultSerial.
- srcB  out  32  operand B to MultSerial.
- prod  in  64  product from MultSerial.
- prodv  in  1  product valid from MultSerial.
- rd_data  out  32  MFHI/MFLO result, combinational.
- stall  out  1  hold the EX stage and all upstream stages.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- err  out  1  sticky multiplier-timeout flag.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, hi=0, lo=0, mst=0, msgn=0, srcA=0, srcB=0, err=0, counter=0. stall and rd_data are combinational: stall=0, rd_data=0 when no read is requested.
- Request priority when more than one is asserted: ex_mult > ex_mthi/ex_mtlo > ex_mfhi/ex_mflo. If both reads are asserted, ex_mfhi wins.
- IDLE, ex_mult=1:
  - mst=1 combinationally in that cycle; msgn/srcA/srcB driven directly from ex_signed/ex_a/ex_b.
  - At the edge, operands are latched into the msgn/srcA/srcB registers and the state goes to BUSY. stall=0, so the instruction retires.
- BUSY:
  - mst=0; msgn/srcA/srcB held constant.
  - stall=1 whenever any ex_* request is asserted; otherwise stall=0, so independent instructions flow.
- BUSY, prodv=1:
  - hi<=prod[63:32] and lo<=prod[31:0] at the edge; state goes to IDLE.
  - Same-cycle MFHI/MFLO is bypassed: rd_data=prod[63:32] or prod[31:0], stall=0.
  - Same-cycle MTHI/MTLO or a new ex_mult keeps stall=1. It is then accepted from IDLE in the next cycle, so the MT write overrides the product.
- IDLE, MTHI/MTLO: write ex_wdata to hi and/or lo at the edge. If both are asserted, both registers take ex_wdata.
- IDLE, MFHI/MFLO: rd_data = current hi/lo, zero-latency.
- A same-cycle read and write of the same register cannot occur, because writes have priority over reads.
- prodv while IDLE is ignored: hi/lo unchanged.
- Multiply latency is whatever MultSerial takes; completion is tracked only through prodv.
- Reset mid-operation: returns to IDLE, drops stall and clears hi/lo. MultSerial shares rst.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_CYC with prodv=0: err<=1 (sticky until rst), state<=IDLE, hi/lo unchanged, stalled requests released.
- Undefined: no counter logic is built; err tied to 0; BUSY persists until prodv.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, BUSY);
  - MULT_W=32 and PROD_W=64;
  - MAX_CYC default.
- One sub-module, mult_timeout_cnt, holding the counter and compare. Instantiated only under MULT_TIMEOUT_EN.
- Everything else stays flat in mult_hilo_ctrl.

Test Plan:
- Signed multiply: ex_mult, ex_signed=1, ex_a=0x00FFFFFF, ex_b=0x80FFFFFF -> one mst pulse with srcA/srcB/msgn stable until prodv; then hi=0xFF810000, lo=0x7E000001.
- Unsigned multiply with the same operands (ex_signed=0) -> hi=0x0080FFFF, lo=0x7E000001.
- MFHI issued the cycle after MULT -> stall=1 until prodv; in the prodv cycle rd_data=prod[63:32] and stall=0.
- MTHI 0x12345678 and MTLO 0xCAFEF00D in IDLE -> hi/lo updated next edge; following MFLO returns 0xCAFEF00D with stall=0.
- rst asserted for one cycle mid-BUSY -> next cycle state=IDLE, stall=0, hi=lo=0, mst=0; a later prodv is ignored.
- With MULT_TIMEOUT_EN and prodv held low -> err=1 after exactly MAX_CYC BUSY cycles, state=IDLE, hi/lo unchanged; without the macro, err stays 0.
